// File: rtl/hnm_rmw_bitmap_pkg.sv
// Shared defaults and fill-engine state type for the hit-node-map bitmap.
package hnm_rmw_bitmap_pkg;

    localparam int DEF_ROWBITS = 6;
    localparam int DEF_COLBITS = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_FILL
    } fillState_t;

endpackage

// File: rtl/hnm_rmw_bitmap_bram.sv
// NROWS x NCOLS block RAM: one write port, two synchronous read ports (old data on collision).
module hnm_bram #(
    parameter int ROWBITS = 6,
    parameter int NCOLS   = 8
) (
    input  logic               clk,
    input  logic               we,
    input  logic [ROWBITS-1:0] wAddr,
    input  logic [NCOLS-1:0]   wData,
    input  logic [ROWBITS-1:0] rAddrA,
    output logic [NCOLS-1:0]   rDataA,
    input  logic [ROWBITS-1:0] rAddrB,
    output logic [NCOLS-1:0]   rDataB
);

    logic [NCOLS-1:0] mem [2**ROWBITS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wAddr] <= wData;
        end
        rDataA <= mem[rAddrA];
        rDataB <= mem[rAddrB];
    end

endmodule

// File: rtl/hnm_rmw_bitmap.sv
// Hit-node-map bitmap: pipelined SSID bit set (RMW with forwarding), row write/read,
// SSID bit read with commit-stage bypass, and a sequential row-fill engine.
module hnm_rmw_bitmap
    import hnm_rmw_bitmap_pkg::*;
#(
    parameter int  ROWBITS       = DEF_ROWBITS,
    parameter int  COLBITS       = DEF_COLBITS,
    parameter int  SSIDBITS      = ROWBITS + COLBITS,
    parameter bit  FILL_ON_RESET = 1'b1,
    localparam int NROWS         = 2 ** ROWBITS,
    localparam int NCOLS         = 2 ** COLBITS
) (
    input  logic                clk,
    input  logic                reset,
    output logic                writeReady,
    input  logic                write,
    input  logic [SSIDBITS-1:0] SSID_write,
    input  logic                writeRow,
    input  logic [ROWBITS-1:0]  rowWrite,
    input  logic [NCOLS-1:0]    dataWrite,
    output logic                readReady,
    input  logic                read,
    input  logic [SSIDBITS-1:0] SSID_read,
    input  logic                readRow,
    input  logic [ROWBITS-1:0]  rowRead,
    input  logic                fillSequentialRows,
    input  logic [NCOLS-1:0]    fillData,
    output logic [SSIDBITS-1:0] SSID_passed,
    output logic                HNM_readOutput,
    output logic                ssidValid,
    output logic [ROWBITS-1:0]  rowPassed,
    output logic [NCOLS-1:0]    rowReadOutput,
    output logic                rowValid,
    output logic                readCollision,
    output logic                busy
);

    fillState_t         state, stateNext;
    logic [ROWBITS-1:0] fillRow;
    logic [NCOLS-1:0]   fillPattern;

    logic               wrAccept, wrSetBit;
    logic [ROWBITS-1:0] wrSsidRow, wrRow;

    logic               s1Valid, s1SetBit, s1HasRow;
    logic [ROWBITS-1:0] s1Row;
    logic [COLBITS-1:0] s1Col;
    logic [NCOLS-1:0]   s1RowData;

    logic               cValid;
    logic [ROWBITS-1:0] cRow;
    logic [NCOLS-1:0]   cData;

    logic [NCOLS-1:0]   ramDataA, ramDataB, oldRow, newRow;
    logic               ramWe;
    logic [ROWBITS-1:0] ramWAddr;
    logic [NCOLS-1:0]   ramWData;

    logic               rdAccept;
    logic [ROWBITS-1:0] rdRowAddr;
    logic               r1Valid, r1IsRow, r1Coll;
    logic [ROWBITS-1:0] r1Row;
    logic [COLBITS-1:0] r1Col;
    logic [NCOLS-1:0]   r1Data;

    assign busy       = (state != ST_IDLE);
    assign writeReady = !busy;
    assign readReady  = !busy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= FILL_ON_RESET ? ST_FILL : ST_IDLE;
            fillRow     <= '0;
            fillPattern <= '0;
        end else begin
            state <= stateNext;
            if (state == ST_IDLE && fillSequentialRows) begin
                fillPattern <= fillData;
            end
            if (state == ST_FILL) begin
                fillRow <= fillRow + ROWBITS'(1);
            end
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            ST_IDLE:  if (fillSequentialRows) stateNext = ST_DRAIN;
            ST_DRAIN: if (!s1Valid) stateNext = ST_FILL;
            ST_FILL:  if (fillRow == ROWBITS'(NROWS - 1)) stateNext = ST_IDLE;
            default:  stateNext = ST_IDLE;
        endcase
    end

    assign wrAccept  = (write | writeRow) & writeReady;
    assign wrSsidRow = SSID_write[SSIDBITS-1:COLBITS];
    assign wrRow     = writeRow ? rowWrite : wrSsidRow;
    // A bit set merges into a row overwrite only when both target the same row.
    assign wrSetBit  = write & (!writeRow | (wrSsidRow == rowWrite));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1Valid   <= 1'b0;
            s1SetBit  <= 1'b0;
            s1HasRow  <= 1'b0;
            s1Row     <= '0;
            s1Col     <= '0;
            s1RowData <= '0;
            cValid    <= 1'b0;
            cRow      <= '0;
            cData     <= '0;
        end else begin
            s1Valid   <= wrAccept;
            s1SetBit  <= wrSetBit;
            s1HasRow  <= writeRow;
            s1Row     <= wrRow;
            s1Col     <= SSID_write[COLBITS-1:0];
            s1RowData <= dataWrite;
            cValid    <= s1Valid;
            cRow      <= s1Row;
            cData     <= newRow;
        end
    end

    // RAM read of stage 1 missed the commit of the previous cycle; take it from cData.
    always_comb begin
        oldRow = (cValid && (cRow == s1Row)) ? cData : ramDataA;
        newRow = (s1HasRow ? s1RowData : oldRow) | (s1SetBit ? (NCOLS'(1) << s1Col) : '0);
    end

    always_comb begin
        ramWe    = s1Valid;
        ramWAddr = s1Row;
        ramWData = newRow;
        if (state == ST_FILL) begin
            ramWe    = 1'b1;
            ramWAddr = fillRow;
            ramWData = fillPattern;
        end
    end

    hnm_bram #(
        .ROWBITS(ROWBITS),
        .NCOLS  (NCOLS)
    ) uBram (
        .clk   (clk),
        .we    (ramWe),
        .wAddr (ramWAddr),
        .wData (ramWData),
        .rAddrA(wrRow),
        .rDataA(ramDataA),
        .rAddrB(rdRowAddr),
        .rDataB(ramDataB)
    );

    assign rdAccept  = (read | readRow) & readReady;
    assign rdRowAddr = readRow ? rowRead : SSID_read[SSIDBITS-1:COLBITS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r1Valid <= 1'b0;
            r1IsRow <= 1'b0;
            r1Coll  <= 1'b0;
            r1Row   <= '0;
            r1Col   <= '0;
        end else begin
            r1Valid <= rdAccept;
            r1IsRow <= readRow;
            r1Coll  <= read & readRow;
            r1Row   <= rdRowAddr;
            r1Col   <= SSID_read[COLBITS-1:0];
        end
    end

    assign r1Data = (cValid && (cRow == r1Row)) ? cData : ramDataB;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rowValid       <= 1'b0;
            ssidValid      <= 1'b0;
            readCollision  <= 1'b0;
            rowPassed      <= '0;
            rowReadOutput  <= '0;
            SSID_passed    <= '0;
            HNM_readOutput <= 1'b0;
        end else begin
            rowValid      <= r1Valid & r1IsRow;
            ssidValid     <= r1Valid & !r1IsRow;
            readCollision <= r1Valid & r1Coll;
            if (r1Valid && r1IsRow) begin
                rowPassed     <= r1Row;
                rowReadOutput <= r1Data;
            end
            if (r1Valid && !r1IsRow) begin
                SSID_passed    <= {r1Row, r1Col};
                HNM_readOutput <= r1Data[r1Col];
            end
        end
    end

endmodule
